mesi_request_sequencer: RTL and testbench

// - Upstream sequencer for the MESI action block in a direct-mapped L1 cache.
// - Accepts CPU load/store requests and holds the per-line tag and MESI state arrays.
// - Classifies each request as hit or miss, and runs the bus transactions: writeback, BusRd, BusRdX, BusUpgr.
// - Presents {status_q, read_write} to the action block for one cycle, then writes the returned status_n back.

---
 rtl/mesi_request_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_mesi_request_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mesi_request_sequencer.sv
// Request sequencer for a direct-mapped L1: tag/MESI arrays, hit/miss classification and bus phases.
// Optional snoop-invalidate support is enabled with `define SNOOP_INV_EN.
module mesi_request_sequencer #(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  output logic              cpu_req_ready,
  output logic              cpu_resp_valid,
  output logic              cpu_resp_hit,
  output logic              act_valid,
  output logic [1:0]        status_q,
  output logic [2:0]        read_write,
  input  logic [1:0]        status_n,
  input  logic              rden,
  output logic              fill_rden,
  output logic              bus_req,
  output logic [1:0]        bus_cmd,
  output logic [ADDR_W-1:0] bus_addr,
`ifdef SNOOP_INV_EN
  input  logic              snoop_valid,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic              snoop_inv,
  output logic              snoop_hit,
`endif
  input  logic              bus_done,
  input  logic              bus_shared
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_M = 2'b01;
  localparam logic [1:0] ST_S = 2'b10;

  localparam logic [1:0] CMD_RD   = 2'b00;
  localparam logic [1:0] CMD_RDX  = 2'b01;
  localparam logic [1:0] CMD_UPGR = 2'b10;
  localparam logic [1:0] CMD_WB   = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_FILL, S_ACT, S_RESP} fsm_t;
  fsm_t state_reg, state_next;

  logic [1:0]       mesi_arr [LINES];
  logic [TAG_W-1:0] tag_arr  [LINES];

  logic [TAG_W-1:0]   req_tag_reg, victim_tag_reg;
  logic [INDEX_W-1:0] req_idx_reg;
  logic               req_we_reg, hit_reg, bus_used_reg, shared_reg, fill_rden_reg;
  logic [1:0]         line_state_reg, cmd_reg;

  logic [1:0]       cur_state;
  logic [TAG_W-1:0] cur_tag;
  logic             lk_hit, lk_direct, lk_wb;
  logic             replay, act_fire;
  logic [INDEX_W-1:0] snp_idx;
  logic             snp_upd;
  logic [1:0]       snp_state;
  logic [LINES-1:0] line_act_we, line_snp_we;
  logic             unused_offset_bits;

  assign cur_state = mesi_arr[req_idx_reg];
  assign cur_tag   = tag_arr[req_idx_reg];
  assign lk_hit    = (cur_tag == req_tag_reg) && (cur_state != ST_I);
  // Loads hit in any valid state; stores only proceed directly from M or E (bit0 set).
  assign lk_direct = lk_hit && (!req_we_reg || cur_state[0]);
  assign lk_wb     = !lk_hit && (cur_state == ST_M);

`ifdef SNOOP_INV_EN
  logic [TAG_W-1:0] snp_tag;
  logic [1:0]       snp_cur;
  logic             snp_match, snoop_hit_reg;

  assign snp_idx   = snoop_addr[OFFSET_W +: INDEX_W];
  assign snp_tag   = snoop_addr[ADDR_W-1 -: TAG_W];
  assign snp_cur   = mesi_arr[snp_idx];
  assign snp_match = snoop_valid && (tag_arr[snp_idx] == snp_tag) && (snp_cur != ST_I);
  assign snp_upd   = snp_match && (snoop_inv || snp_cur[0]);
  assign snp_state = snoop_inv ? ST_I : ST_S;
  assign replay    = snoop_valid && (snp_idx == req_idx_reg) &&
                     ((state_reg == S_LOOKUP) || (state_reg == S_ACT));
  assign snoop_hit = snoop_hit_reg;
  assign unused_offset_bits = ^{cpu_req_addr[OFFSET_W-1:0], snoop_addr[OFFSET_W-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) snoop_hit_reg <= 1'b0;
    else     snoop_hit_reg <= snp_match;
  end
`else
  assign snp_idx   = '0;
  assign snp_upd   = 1'b0;
  assign snp_state = ST_I;
  assign replay    = 1'b0;
  assign unused_offset_bits = ^cpu_req_addr[OFFSET_W-1:0];
`endif

  assign act_fire = (state_reg == S_ACT) && !replay;

  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_line_we
      assign line_act_we[gi] = act_fire && (req_idx_reg == INDEX_W'(gi));
      assign line_snp_we[gi] = snp_upd && (snp_idx == INDEX_W'(gi));
    end
  endgenerate

  // Snoop write comes last so it wins; a same-index snoop in ACT already suppressed the ACT write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) begin
        mesi_arr[i] <= ST_I;
        tag_arr[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < LINES; i++) begin
        if (line_act_we[i]) begin
          mesi_arr[i] <= status_n;
          tag_arr[i]  <= req_tag_reg;
        end
        if (line_snp_we[i]) mesi_arr[i] <= snp_state;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (cpu_req_valid) state_next = S_LOOKUP;
      S_LOOKUP: begin
        if (replay)         state_next = S_LOOKUP;
        else if (lk_direct) state_next = S_ACT;
        else if (lk_wb)     state_next = S_WB;
        else                state_next = S_FILL;
      end
      S_WB:     if (bus_done) state_next = S_FILL;
      S_FILL:   if (bus_done) state_next = S_ACT;
      S_ACT:    state_next = replay ? S_LOOKUP : S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_tag_reg    <= '0;
      req_idx_reg    <= '0;
      req_we_reg     <= 1'b0;
      hit_reg        <= 1'b0;
      bus_used_reg   <= 1'b0;
      line_state_reg <= ST_I;
      victim_tag_reg <= '0;
      cmd_reg        <= CMD_RD;
      shared_reg     <= 1'b0;
      fill_rden_reg  <= 1'b0;
    end else begin
      fill_rden_reg <= act_fire && rden;
      case (state_reg)
        S_IDLE: if (cpu_req_valid) begin
          req_tag_reg <= cpu_req_addr[ADDR_W-1 -: TAG_W];
          req_idx_reg <= cpu_req_addr[OFFSET_W +: INDEX_W];
          req_we_reg  <= cpu_req_we;
        end
        S_LOOKUP: begin
          hit_reg        <= lk_hit;
          bus_used_reg   <= !lk_direct;
          line_state_reg <= cur_state;
          victim_tag_reg <= cur_tag;
          cmd_reg        <= lk_hit ? CMD_UPGR : (req_we_reg ? CMD_RDX : CMD_RD);
          shared_reg     <= 1'b0;
        end
        S_FILL: if (bus_done) shared_reg <= bus_shared;
        default: ;
      endcase
    end
  end

  always_comb begin
    cpu_req_ready  = (state_reg == S_IDLE);
    cpu_resp_valid = (state_reg == S_RESP);
    cpu_resp_hit   = (state_reg == S_RESP) && hit_reg && !bus_used_reg;
    act_valid      = act_fire;
    status_q       = ST_I;
    read_write     = 3'b000;
    if (act_fire) begin
      status_q = hit_reg ? line_state_reg : ST_I;
      if (req_we_reg)      read_write = hit_reg ? 3'b000 : 3'b010;
      else if (hit_reg)    read_write = 3'b001;
      else                 read_write = shared_reg ? 3'b100 : 3'b011;
    end
    fill_rden = fill_rden_reg;
    bus_req   = (state_reg == S_WB) || (state_reg == S_FILL);
    bus_cmd   = (state_reg == S_WB) ? CMD_WB : cmd_reg;
    bus_addr  = (state_reg == S_WB) ? {victim_tag_reg, req_idx_reg, {OFFSET_W{1'b0}}}
                                    : {req_tag_reg, req_idx_reg, {OFFSET_W{1'b0}}};
  end

endmodule

// File: tb/tb_mesi_request_sequencer.sv
// Scoreboard bench for mesi_request_sequencer: directed requests, bus responder and output monitor.
module tb_mesi_request_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req_valid = 1'b0, cpu_req_we = 1'b0;
  logic [31:0] cpu_req_addr = '0;
  logic        cpu_req_ready, cpu_resp_valid, cpu_resp_hit, act_valid;
  logic [1:0]  status_q;
  logic [2:0]  read_write;
  logic [1:0]  status_n = 2'b00;
  logic        rden = 1'b0, fill_rden, bus_req;
  logic [1:0]  bus_cmd;
  logic [31:0] bus_addr;
  logic        bus_done = 1'b0, bus_shared = 1'b0;
`ifdef SNOOP_INV_EN
  logic        snoop_valid = 1'b0, snoop_inv = 1'b0, snoop_hit;
  logic [31:0] snoop_addr = '0;
`endif

  mesi_request_sequencer dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr),
    .cpu_req_ready(cpu_req_ready), .cpu_resp_valid(cpu_resp_valid), .cpu_resp_hit(cpu_resp_hit),
    .act_valid(act_valid), .status_q(status_q), .read_write(read_write),
    .status_n(status_n), .rden(rden), .fill_rden(fill_rden),
    .bus_req(bus_req), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
`ifdef SNOOP_INV_EN
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .snoop_inv(snoop_inv), .snoop_hit(snoop_hit),
`endif
    .bus_done(bus_done), .bus_shared(bus_shared)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] sq; logic [2:0] rw; logic hit; logic frd; } exp_t;
  typedef struct packed { logic [1:0] cmd; logic [31:0] addr; } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];
  int   total = 0, bad = 0, bus_seen = 0, txn = 0;
  logic shared_cfg = 1'b0;

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  // Monitor: compares action-block and response outputs against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (act_valid === 1'b1) begin
        if (exp_q.size() == 0) check("act_unexpected", 1, 0);
        else begin
          check("act_status_q", status_q, exp_q[0].sq);
          check("act_read_write", read_write, exp_q[0].rw);
        end
      end
      if (cpu_resp_valid === 1'b1) begin
        if (exp_q.size() == 0) check("resp_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("resp_hit", cpu_resp_hit, e.hit);
          check("fill_rden", fill_rden, e.frd);
          txn++;
          $display("txn %0d: resp hit=%0d fill_rden=%0d", txn, cpu_resp_hit, fill_rden);
        end
      end
    end
  end

  // Bus responder: completes each bus command two cycles after it appears and checks cmd/addr.
  initial begin
    int cnt = 0;
    bus_t b;
    forever begin
      @(negedge clk);
      if (bus_done) bus_done = 1'b0;
      else if (bus_req === 1'b1) begin
        cnt++;
        if (cnt == 2) begin
          cnt = 0;
          if (bus_q.size() == 0) check("bus_unexpected", {30'd0, bus_cmd}, 32'hffff);
          else begin
            b = bus_q.pop_front();
            check("bus_cmd", {30'd0, bus_cmd}, {30'd0, b.cmd});
            check("bus_addr", bus_addr, b.addr);
          end
          bus_seen++;
          bus_shared = shared_cfg;
          bus_done   = 1'b1;
        end
      end else cnt = 0;
    end
  end

  task automatic push_bus(input logic [1:0] cmd, input logic [31:0] addr);
    bus_q.push_back('{cmd: cmd, addr: addr});
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] sn,
                       input logic rd, input logic sh, input logic [1:0] esq,
                       input logic [2:0] erw, input logic ehit);
    int cyc, b0;
    bit got;
    exp_q.push_back('{sq: esq, rw: erw, hit: ehit, frd: rd});
    status_n = sn; rden = rd; shared_cfg = sh;
    @(negedge clk);
    cyc = 0;
    while (!cpu_req_ready && cyc < 50) begin @(negedge clk); cyc++; end
    if (!cpu_req_ready) check("ready_timeout", 0, 1);
    cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = addr;
    b0 = bus_seen;
    @(posedge clk); #1 cpu_req_valid = 1'b0;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge clk); cyc++;
      if (cpu_resp_valid) got = 1'b1;
    end
    check("resp_timeout", {31'd0, got}, 1);
    if (ehit) begin
      check("hit_latency", cyc, 3);
      check("hit_no_bus", bus_seen - b0, 0);
    end
  endtask

  initial begin
    int cyc;
    #1 rst = 1'b1;
    #1;
    check("rst_ready", cpu_req_ready, 1);
    check("rst_bus_req", bus_req, 0);
    check("rst_act_valid", act_valid, 0);
    check("rst_resp_valid", cpu_resp_valid, 0);
    check("rst_fill_rden", fill_rden, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    push_bus(2'b00, 32'h100);
    issue(1'b0, 32'h100, 2'b11, 1'b1, 1'b0, 2'b00, 3'b011, 1'b0);
    issue(1'b0, 32'h104, 2'b11, 1'b0, 1'b0, 2'b11, 3'b001, 1'b1);
    push_bus(2'b00, 32'h200);
    issue(1'b0, 32'h200, 2'b10, 1'b1, 1'b1, 2'b00, 3'b100, 1'b0);
    push_bus(2'b10, 32'h200);
    issue(1'b1, 32'h200, 2'b01, 1'b0, 1'b0, 2'b10, 3'b000, 1'b0);
    push_bus(2'b11, 32'h200); push_bus(2'b01, 32'h100);
    issue(1'b1, 32'h100, 2'b01, 1'b1, 1'b0, 2'b00, 3'b010, 1'b0);
    push_bus(2'b11, 32'h100); push_bus(2'b00, 32'h1100);
    issue(1'b0, 32'h1100, 2'b11, 1'b0, 1'b0, 2'b00, 3'b011, 1'b0);
    push_bus(2'b01, 32'h300);
    issue(1'b1, 32'h300, 2'b01, 1'b1, 1'b0, 2'b00, 3'b010, 1'b0);
    issue(1'b0, 32'h300, 2'b01, 1'b0, 1'b0, 2'b01, 3'b001, 1'b1);
    issue(1'b1, 32'h308, 2'b01, 1'b1, 1'b0, 2'b01, 3'b000, 1'b1);
    push_bus(2'b00, 32'h010);
    issue(1'b0, 32'h010, 2'b10, 1'b0, 1'b1, 2'b00, 3'b100, 1'b0);

`ifdef SNOOP_INV_EN
    @(negedge clk);
    snoop_valid = 1'b1; snoop_addr = 32'h300; snoop_inv = 1'b1;
    @(negedge clk);
    snoop_valid = 1'b0;
    check("snoop_hit", snoop_hit, 1);
    push_bus(2'b00, 32'h300);
    issue(1'b0, 32'h300, 2'b11, 1'b0, 1'b0, 2'b00, 3'b011, 1'b0);
`endif

    // Abort a miss mid-fill with an asynchronous reset.
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'h150;
    @(posedge clk); #1 cpu_req_valid = 1'b0;
    cyc = 0;
    while (bus_req !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    check("abort_bus_req_seen", bus_req, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_bus_req_drop", bus_req, 0);
    check("abort_ready", cpu_req_ready, 1);
    check("abort_act_valid", act_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    push_bus(2'b00, 32'h300);
    issue(1'b0, 32'h300, 2'b11, 1'b0, 1'b0, 2'b00, 3'b011, 1'b0);

    repeat (5) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    check("bus_q_empty", bus_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
